// File: rtl/systolic_skew_buffer_pkg.sv
// Shared types and helpers for the systolic skew buffer.
// Lane depth is computed here so the top and any bench agree on a single formula.
package tpu_skew_pkg;

   typedef enum logic {
      SKEW_MODE   = 1'b0,
      DESKEW_MODE = 1'b1
   } skew_mode_e;

   localparam int MAX_EXTRA_LAT = 4;

   // Number of register stages between input and output for a given lane.
   // Skew staircases operands (lane i later by i); deskew undoes that staircase.
   function automatic int lane_depth(input int lane, input int lanes,
                                     input skew_mode_e mode, input int extra_lat);
      if (mode == SKEW_MODE) begin
         return 1 + extra_lat + lane;
      end
      return 1 + extra_lat + (lanes - 1 - lane);
   endfunction

endpackage

// File: rtl/systolic_skew_buffer_lane.sv
// skew_lane: one lane's {valid, data} delay line with shift/hold/flush and a tapped output.
// Optional build macro SKEW_ZERO_FILL_EN forces out_data to zero whenever out_valid is low.
module skew_lane #(
   parameter int DEPTH_MAX = 16,
   parameter int DATA_W    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         shift_en,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            in_data,
   input  logic [$clog2(DEPTH_MAX)-1:0] tap,
   output logic                         out_valid,
   output logic [DATA_W-1:0]            out_data,
   output logic                         any_valid
);

   // Stage 0 is the newest entry; stage DEPTH_MAX-1 is the oldest.
   logic [DEPTH_MAX-1:0]             valid_q;
   logic [DEPTH_MAX-1:0][DATA_W-1:0] data_q;

   // Shift on shift_en, otherwise hold; flush clears every valid bit even while holding.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         if (shift_en) begin
            valid_q <= {valid_q[DEPTH_MAX-2:0], in_valid};
            data_q  <= {data_q[DEPTH_MAX-2:0], in_data};
         end
         if (flush) begin
            valid_q <= '0;
         end
      end
   end

   assign out_valid = valid_q[tap];
   assign any_valid = |valid_q;

`ifdef SKEW_ZERO_FILL_EN
   // Bubbles read as zero operands so the array needs no extra gating.
   assign out_data = valid_q[tap] ? data_q[tap] : '0;
`else
   // Raw tap contents; stale data may show while out_valid is low.
   assign out_data = data_q[tap];
`endif

endmodule

// File: rtl/systolic_skew_buffer.sv
// systolic_skew_buffer: per-lane staircase (skew) or realignment (deskew) of a parallel vector.
// Optional build macro SKEW_ZERO_FILL_EN zeroes out_data on lanes whose out_valid is low.
//
// Flow control: there is no ready. in_valid is sampled only on edges with shift_en=1;
// the producer stalls by dropping shift_en, which freezes every stage and every output.
// out_valid[i] qualifies out_data[i] independently per lane.
module systolic_skew_buffer
   import tpu_skew_pkg::*;
#(
   parameter int LANES     = 16,
   parameter int DATA_W    = 8,
   parameter int EXTRA_LAT = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mode,
   input  logic                         shift_en,
   input  logic                         in_valid,
   input  logic [LANES-1:0][DATA_W-1:0] in_data,
   input  logic                         flush,
   output logic [LANES-1:0][DATA_W-1:0] out_data,
   output logic [LANES-1:0]             out_valid,
   output logic                         busy,
   output logic                         mode_q
);

   // Every lane carries enough stages for the deepest tap in either mode.
   localparam int DEPTH_MAX = 1 + EXTRA_LAT + (LANES - 1);
   localparam int TAP_W     = $clog2(DEPTH_MAX);

   if (LANES < 2 || EXTRA_LAT < 0 || EXTRA_LAT > MAX_EXTRA_LAT) begin : g_bad_cfg
      $error("systolic_skew_buffer: unsupported LANES/EXTRA_LAT");
   end

   skew_mode_e       mode_r;
   logic [LANES-1:0] lane_busy;

   // Mode only changes with the pipeline empty, so in-flight vectors never see a tap jump.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_r <= SKEW_MODE;
      end else if (!busy) begin
         mode_r <= skew_mode_e'(mode);
      end
   end

   assign busy   = |lane_busy;
   assign mode_q = mode_r;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam logic [TAP_W-1:0] TAP_SKEW =
         TAP_W'(lane_depth(i, LANES, SKEW_MODE, EXTRA_LAT) - 1);
      localparam logic [TAP_W-1:0] TAP_DESKEW =
         TAP_W'(lane_depth(i, LANES, DESKEW_MODE, EXTRA_LAT) - 1);

      logic [TAP_W-1:0] tap;
      assign tap = (mode_r == DESKEW_MODE) ? TAP_DESKEW : TAP_SKEW;

      skew_lane #(
         .DEPTH_MAX(DEPTH_MAX),
         .DATA_W   (DATA_W)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .shift_en (shift_en),
         .flush    (flush),
         .in_valid (in_valid),
         .in_data  (in_data[i]),
         .tap      (tap),
         .out_valid(out_valid[i]),
         .out_data (out_data[i]),
         .any_valid(lane_busy[i])
      );
   end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Directed bench for systolic_skew_buffer with LANES=4, DATA_W=8, EXTRA_LAT=0.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_systolic_skew_buffer;

   localparam int LANES  = 4;
   localparam int DATA_W = 8;

   logic                         clk;
   logic                         rst;
   logic                         mode;
   logic                         shift_en;
   logic                         in_valid;
   logic [LANES-1:0][DATA_W-1:0] in_data;
   logic                         flush;
   logic [LANES-1:0][DATA_W-1:0] out_data;
   logic [LANES-1:0]             out_valid;
   logic                         busy;
   logic                         mode_q;

   int n_checks = 0;
   int n_fail   = 0;

   systolic_skew_buffer #(
      .LANES    (LANES),
      .DATA_W   (DATA_W),
      .EXTRA_LAT(0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .shift_en (shift_en),
      .in_valid (in_valid),
      .in_data  (in_data),
      .flush    (flush),
      .out_data (out_data),
      .out_valid(out_valid),
      .busy     (busy),
      .mode_q   (mode_q)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for the pipeline to empty.
   task automatic drain();
      for (int c = 0; c < 20 && busy; c++) tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
      n_checks++;
      if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if (mode_q !== 1'b0) begin n_fail++; $display("FAIL reset_mode_q: got %b expected 0", mode_q); end
   endtask

   // Skew: lane i shows the vector i cycles after lane 0.
   task automatic test_skew();
      logic [3:0] exp_v;
      in_data  = {8'h03, 8'h02, 8'h01, 8'h00};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         exp_v = (k < 4) ? 4'(1 << k) : 4'b0000;
         n_checks++;
         if (out_valid !== exp_v) begin n_fail++; $display("FAIL skew_valid k=%0d: got %b expected %b", k, out_valid, exp_v); end
         n_checks++;
         if (busy !== (k < 4)) begin n_fail++; $display("FAIL skew_busy k=%0d: got %b expected %b", k, busy, (k < 4)); end
         if (k < 4) begin
            n_checks++;
            if (out_data[k] !== 8'(k)) begin n_fail++; $display("FAIL skew_data lane%0d: got %h expected %h", k, out_data[k], 8'(k)); end
            tick();
         end
      end
   endtask

   // Deskew: lane i's value fed at t0+i -> all lanes aligned in one cycle.
   task automatic test_deskew();
      logic [LANES-1:0][DATA_W-1:0] vec;
      mode = 1'b1;
      tick();
      n_checks++;
      if (mode_q !== 1'b1) begin n_fail++; $display("FAIL deskew_mode_q: got %b expected 1", mode_q); end
      for (int j = 0; j < 4; j++) begin
         for (int l = 0; l < 4; l++) vec[l] = (l == j) ? 8'(l) : (8'hF0 | 8'(j));
         in_data  = vec;
         in_valid = 1'b1;
         tick();
         if (j == 2) begin
            n_checks++;
            if (out_valid !== 4'b1110) begin n_fail++; $display("FAIL deskew_valid_pre: got %b expected 1110", out_valid); end
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 4'b1111) begin n_fail++; $display("FAIL deskew_valid_aligned: got %b expected 1111", out_valid); end
      n_checks++;
      if (out_data !== {8'h03, 8'h02, 8'h01, 8'h00}) begin n_fail++; $display("FAIL deskew_data_aligned: got %h expected 03020100", out_data); end
      tick();
      n_checks++;
      if (out_valid !== 4'b0111) begin n_fail++; $display("FAIL deskew_valid_post: got %b expected 0111", out_valid); end
      n_checks++;
      if (out_data[0] !== 8'hF1) begin n_fail++; $display("FAIL deskew_data_lane0_post: got %h expected f1", out_data[0]); end
      drain();
      mode = 1'b0;
      tick();
      n_checks++;
      if (mode_q !== 1'b0) begin n_fail++; $display("FAIL deskew_mode_restore: got %b expected 0", mode_q); end
   endtask

   // Stall for 3 cycles after lane1 emits; latency of later lanes stretches by 3.
   task automatic test_stall();
      logic [3:0] exp_v [7];
      logic       en    [7];
      exp_v = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
      en    = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b1,    1'b1};
      in_data = {8'h13, 8'h12, 8'h11, 8'h10};
      for (int k = 0; k < 7; k++) begin
         shift_en = en[k];
         in_valid = (k == 0);
         tick();
         n_checks++;
         if (out_valid !== exp_v[k]) begin n_fail++; $display("FAIL stall_valid step=%0d: got %b expected %b", k, out_valid, exp_v[k]); end
         if (k >= 1 && k <= 4) begin
            n_checks++;
            if (out_data[1] !== 8'h11) begin n_fail++; $display("FAIL stall_hold_data step=%0d: got %h expected 11", k, out_data[1]); end
         end
      end
      in_valid = 1'b0;
      shift_en = 1'b1;
      n_checks++;
      if (out_data[3] !== 8'h13) begin n_fail++; $display("FAIL stall_data_lane3: got %h expected 13", out_data[3]); end
      tick();
      n_checks++;
      if (out_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_end: got valid=%b busy=%b expected 0000/0", out_valid, busy); end
   endtask

   // Mode requested while busy is deferred until the pipeline drains.
   task automatic test_mode_busy();
      in_data  = {8'h23, 8'h22, 8'h21, 8'h20};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      mode     = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_checks++;
         if (mode_q !== 1'b0) begin n_fail++; $display("FAIL mode_busy_hold k=%0d: got %b expected 0", k, mode_q); end
         if (k == 3) begin
            n_checks++;
            if (out_valid !== 4'b1000 || out_data[3] !== 8'h23) begin n_fail++; $display("FAIL mode_busy_skew_lane3: got %b/%h expected 1000/23", out_valid, out_data[3]); end
         end
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mode_busy_drained: got %b expected 0", busy); end
      tick();
      n_checks++;
      if (mode_q !== 1'b1) begin n_fail++; $display("FAIL mode_busy_latched: got %b expected 1", mode_q); end
      in_data  = {8'h33, 8'h32, 8'h31, 8'h30};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 4'b1000 || out_data[3] !== 8'h33) begin n_fail++; $display("FAIL mode_busy_deskew_first: got %b/%h expected 1000/33", out_valid, out_data[3]); end
      tick();
      tick();
      tick();
      n_checks++;
      if (out_valid !== 4'b0001 || out_data[0] !== 8'h30) begin n_fail++; $display("FAIL mode_busy_deskew_last: got %b/%h expected 0001/30", out_valid, out_data[0]); end
      drain();
      // Idle pipeline: mode change and accept on the same edge use the new mode.
      mode     = 1'b0;
      in_data  = {8'h63, 8'h62, 8'h61, 8'h60};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (mode_q !== 1'b0) begin n_fail++; $display("FAIL same_edge_mode_q: got %b expected 0", mode_q); end
      n_checks++;
      if (out_valid !== 4'b0001 || out_data[0] !== 8'h60) begin n_fail++; $display("FAIL same_edge_skew: got %b/%h expected 0001/60", out_valid, out_data[0]); end
      drain();
   endtask

   // Flush with three vectors in flight and a simultaneous accept.
   task automatic test_flush();
      for (int j = 0; j < 3; j++) begin
         in_data  = {4{8'h40 | 8'(j)}};
         in_valid = 1'b1;
         tick();
      end
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_valid: got %b expected 0000", out_valid); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
`ifdef SKEW_ZERO_FILL_EN
      n_checks++;
      if (out_data !== 32'h0) begin n_fail++; $display("FAIL flush_zero_fill: got %h expected 00000000", out_data); end
`endif
      for (int k = 0; k < 6; k++) begin
         tick();
         n_checks++;
         if (out_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_no_late_valid k=%0d: got %b/%b expected 0000/0", k, out_valid, busy); end
      end
      // Flush also clears while stalled.
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      shift_en = 1'b0;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      shift_en = 1'b1;
      n_checks++;
      if (out_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_stalled: got %b/%b expected 0000/0", out_valid, busy); end
   endtask

   // Reset mid-stream returns to power-up state; next vector sees base latency.
   task automatic test_reset_mid();
      mode = 1'b1;
      tick();
      n_checks++;
      if (mode_q !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre_mode: got %b expected 1", mode_q); end
      in_data  = {4{8'hA5}};
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 4'b0000 || out_data !== 32'h0) begin n_fail++; $display("FAIL reset_mid_outputs: got %b/%h expected 0000/00000000", out_valid, out_data); end
      n_checks++;
      if (busy !== 1'b0 || mode_q !== 1'b0) begin n_fail++; $display("FAIL reset_mid_state: got busy=%b mode_q=%b expected 0/0", busy, mode_q); end
      mode     = 1'b0;
      in_data  = {8'h53, 8'h52, 8'h51, 8'h50};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (out_valid !== 4'(1 << k) || out_data[k] !== (8'h50 | 8'(k))) begin
            n_fail++;
            $display("FAIL reset_mid_latency lane%0d: got %b/%h expected %b/%h", k, out_valid, out_data[k], 4'(1 << k), 8'h50 | 8'(k));
         end
         tick();
      end
   endtask

   initial begin
      rst      = 1'b1;
      mode     = 1'b0;
      shift_en = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      flush    = 1'b0;
      test_reset();
      test_skew();
      test_deskew();
      test_stall();
      test_mode_busy();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
